// File: rtl/exec_unit.sv
// Execute/write-back stage in front of a small register file: latches one op,
// reads operands through the file's select ports, computes and writes back the result.
module exec_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [3:0]        op_code_i,
    input  logic [SEL_W-1:0]  rd_i,
    input  logic [SEL_W-1:0]  rs1_i,
    input  logic [SEL_W-1:0]  rs2_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [SEL_W-1:0]  rf_out1_sel_o,
    output logic [SEL_W-1:0]  rf_out2_sel_o,
    input  logic [DATA_W-1:0] rf_out1_i,
    input  logic [DATA_W-1:0] rf_out2_i,
    output logic [DATA_W-1:0] rf_in_o,
    output logic [SEL_W-1:0]  rf_in_sel_o,
    output logic              rf_in_en_o,
    output logic              done_o,
    output logic              flag_zero_o,
    output logic              flag_carry_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned ACC_W = 2 * DATA_W;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_e;

    state_e              state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic [SEL_W-1:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0]   imm_q, imm_d, result_q, result_d;
    logic [ACC_W-1:0]    mcand_q, mcand_d, acc_q, acc_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                en_q, en_d, done_q, done_d, ready_q, ready_d;
    logic                zero_q, zero_d, carry_q, carry_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [DATA_W:0]     sum;
    logic [ACC_W-1:0]    shl_w, shr_w, acc_next;
    logic [3:0]          shamt;

    // Single-cycle ALU on the operands returned by the file
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        shamt     = rf_out2_i[3:0];
        sum       = {1'b0, rf_out1_i} + {1'b0, rf_out2_i};
        shl_w     = ACC_W'(rf_out1_i) << shamt;
        shr_w     = {rf_out1_i, DATA_W'(0)} >> shamt;
        case (code_q)
            OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
            OP_SUB: begin alu_res = rf_out1_i - rf_out2_i; alu_carry = rf_out1_i < rf_out2_i; end
            OP_AND: alu_res = rf_out1_i & rf_out2_i;
            OP_OR:  alu_res = rf_out1_i | rf_out2_i;
            OP_XOR: alu_res = rf_out1_i ^ rf_out2_i;
            // Bit just past the kept window is the last bit shifted out; zero when shamt==0
            OP_SHL: begin alu_res = shl_w[DATA_W-1:0]; alu_carry = shl_w[DATA_W]; end
            OP_SHR: begin alu_res = shr_w[ACC_W-1:DATA_W]; alu_carry = shr_w[DATA_W-1]; end
            OP_LDI: alu_res = imm_q;
            OP_MOV: alu_res = rf_out1_i;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : ACC_W'(0));

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        result_d = result_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid_i && ready_q) begin
                    code_d  = op_code_i;
                    rd_d    = rd_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    imm_d   = imm_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (code_q == OP_MUL) begin
                    mcand_d  = ACC_W'(rf_out1_i);
                    mplier_d = rf_out2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end else begin
                    state_d = S_WB;
                    done_d  = 1'b1;
                    // Undefined opcodes retire without writing or touching flags
                    if (code_q <= OP_MOV) begin
                        result_d = alu_res;
                        en_d     = 1'b1;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d  = S_WB;
                    result_d = acc_next[DATA_W-1:0];
                    en_d     = 1'b1;
                    done_d   = 1'b1;
                    zero_d   = (acc_next[DATA_W-1:0] == '0);
                    carry_d  = |acc_next[ACC_W-1:DATA_W];
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            result_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            result_q <= result_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign op_ready_o    = ready_q;
    assign rf_out1_sel_o = rs1_q;
    assign rf_out2_sel_o = rs2_q;
    assign rf_in_o       = result_q;
    assign rf_in_sel_o   = rd_q;
    assign rf_in_en_o    = en_q;
    assign done_o        = done_q;
    assign flag_zero_o   = zero_q;
    assign flag_carry_o  = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: register-file stand-in, arithmetic reference model with a
// per-cycle compare process, and directed ops with hand-computed results.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b1;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [3:0]  op_code_i;
    logic [1:0]  rd_i, rs1_i, rs2_i;
    logic [15:0] imm_i;
    logic [1:0]  rf_out1_sel_o, rf_out2_sel_o, rf_in_sel_o;
    logic [15:0] rf_out1_i, rf_out2_i, rf_in_o;
    logic        rf_in_en_o, done_o, flag_zero_o, flag_carry_o;

    exec_unit #(.DATA_W(16), .SEL_W(2)) dut (
        .clk(clk), .reset_ni(reset_ni),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_code_i(op_code_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .rf_out1_sel_o(rf_out1_sel_o), .rf_out2_sel_o(rf_out2_sel_o),
        .rf_out1_i(rf_out1_i), .rf_out2_i(rf_out2_i),
        .rf_in_o(rf_in_o), .rf_in_sel_o(rf_in_sel_o), .rf_in_en_o(rf_in_en_o),
        .done_o(done_o), .flag_zero_o(flag_zero_o), .flag_carry_o(flag_carry_o)
    );

    always #5 clk = ~clk;

    // Register file stand-in
    logic [15:0] tb_rf [4];
    assign rf_out1_i = tb_rf[rf_out1_sel_o];
    assign rf_out2_i = tb_rf[rf_out2_sel_o];
    always @(posedge clk) if (rf_in_en_o) tb_rf[rf_in_sel_o] <= rf_in_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [15:0] mrf [4];
    bit          pend = 1'b0;
    bit          checking = 1'b0;
    int          acc_cyc = 0;
    int          wb_cyc = 0;
    logic        exp_write;
    logic [15:0] exp_data;
    logic [1:0]  exp_sel, exp_rs1, exp_rs2;
    logic        nz, nc;
    logic        mz = 1'b0;
    logic        mc = 1'b0;
    int          last_en_cyc = -1;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] imm, output logic [15:0] r, output logic c,
                                  output logic w);
        logic [16:0] s;
        logic [31:0] p;
        int n;
        w = 1'b1; c = 1'b0; r = 16'h0; n = int'(b[3:0]);
        case (code)
            4'd0: begin s = 17'(a) + 17'(b); r = s[15:0]; c = s[16]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a << n; if (n != 0) c = a[16 - n]; end
            4'd6: begin r = a >> n; if (n != 0) c = a[n - 1]; end
            4'd7: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p[31:16] != 16'h0); end
            4'd8: r = imm;
            4'd9: r = a;
            default: w = 1'b0;
        endcase
    endfunction

    // Per-cycle comparison of handshake, write-back and flags against the model
    always @(negedge clk) begin : cmp
        bit busy, wbn;
        if (done_o === 1'b1) done_cnt++;
        if (rf_in_en_o === 1'b1) last_en_cyc = cyc;
        if (checking) begin
            busy = pend && cyc > acc_cyc && cyc <= wb_cyc;
            wbn  = pend && cyc == wb_cyc;
            if (wbn && exp_write) begin mz = nz; mc = nc; end
            chk("ready", 32'(op_ready_o), 32'(!busy));
            chk("done", 32'(done_o), 32'(wbn));
            chk("wr_en", 32'(rf_in_en_o), 32'(wbn && exp_write));
            if (wbn && exp_write) begin
                chk("wr_data", 32'(rf_in_o), 32'(exp_data));
                chk("wr_sel", 32'(rf_in_sel_o), 32'(exp_sel));
            end
            if (pend && cyc == acc_cyc + 1) begin
                chk("sel1", 32'(rf_out1_sel_o), 32'(exp_rs1));
                chk("sel2", 32'(rf_out2_sel_o), 32'(exp_rs2));
            end
            chk("zero", 32'(flag_zero_o), 32'(mz));
            chk("carry", 32'(flag_carry_o), 32'(mc));
        end
    end

    // Called at posedge+1; waits for ready, presents the op for one cycle
    task automatic issue(input logic [3:0] code, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [15:0] imm);
        int waited = 0;
        logic [15:0] r;
        logic c, w;
        while (op_ready_o !== 1'b1 && waited < 40) begin @(posedge clk); #1; waited++; end
        if (op_ready_o !== 1'b1) begin
            chk("ready_timeout", 32'(op_ready_o), 32'd1);
            return;
        end
        op_code_i = code; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        op_valid_i = 1'b1;
        model(code, mrf[rs1], mrf[rs2], imm, r, c, w);
        pend = 1'b1;
        acc_cyc = cyc;
        wb_cyc = cyc + 2 + ((code == 4'd7) ? 16 : 0);
        exp_write = w; exp_data = r; exp_sel = rd; exp_rs1 = rs1; exp_rs2 = rs2;
        nz = (r == 16'h0); nc = c;
        if (w) mrf[rd] = r;
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        op_code_i = 4'($urandom);
        imm_i = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc <= wb_cyc && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic run(input string nm, input logic [3:0] code, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [15:0] imm,
                       input logic [15:0] val, input logic c);
        issue(code, rd, rs1, rs2, imm);
        wait_idle();
        chk({nm, "_rd"}, 32'(tb_rf[rd]), 32'(val));
        chk({nm, "_c"}, 32'(flag_carry_o), 32'(c));
    endtask

    initial begin : main
        int a, d0, mul_acc;
        logic [15:0] old;
        op_valid_i = 1'b0; op_code_i = 4'd0; rd_i = 2'd0; rs1_i = 2'd0; rs2_i = 2'd0; imm_i = 16'h0;
        #2 reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(op_ready_o), 32'd1);
        chk("rst_en", 32'(rf_in_en_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_zero", 32'(flag_zero_o), 32'd0);
        chk("rst_carry", 32'(flag_carry_o), 32'd0);
        chk("rst_data", 32'(rf_in_o), 32'd0);
        chk("rst_sels", 32'({rf_out1_sel_o, rf_out2_sel_o, rf_in_sel_o}), 32'd0);
        reset_ni = 1'b1;
        checking = 1'b1;
        @(posedge clk); #1;

        run("t1_ldi1", 4'd8, 2'd1, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        run("t1_ldi2", 4'd8, 2'd2, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0);
        run("t1_add", 4'd0, 2'd3, 2'd1, 2'd2, 16'h0, 16'h0000, 1'b1);
        chk("t1_zero", 32'(flag_zero_o), 32'd1);
        chk("t1_lat", 32'(last_en_cyc - acc_cyc), 32'd2);

        run("t2_ldi1", 4'd8, 2'd1, 2'd0, 2'd0, 16'h0003, 16'h0003, 1'b0);
        run("t2_ldi2", 4'd8, 2'd2, 2'd0, 2'd0, 16'h0005, 16'h0005, 1'b0);
        run("t2_sub", 4'd1, 2'd0, 2'd1, 2'd2, 16'h0, 16'hFFFE, 1'b1);
        chk("t2_zero", 32'(flag_zero_o), 32'd0);

        run("t3_ldi1", 4'd8, 2'd1, 2'd0, 2'd0, 16'd300, 16'd300, 1'b0);
        run("t3_ldi2", 4'd8, 2'd2, 2'd0, 2'd0, 16'd300, 16'd300, 1'b0);
        run("t3_mul", 4'd7, 2'd2, 2'd1, 2'd2, 16'h0, 16'h5F90, 1'b1);
        chk("t3_lat", 32'(last_en_cyc - acc_cyc), 32'd18);

        run("t4_ldi", 4'd8, 2'd1, 2'd0, 2'd0, 16'd7, 16'd7, 1'b0);
        a = acc_cyc;
        run("t4_add", 4'd0, 2'd2, 2'd1, 2'd1, 16'h0, 16'd14, 1'b0);
        chk("t4_accept_gap", 32'(acc_cyc - a), 32'd3);

        run("sh_ldi0", 4'd8, 2'd0, 2'd0, 2'd0, 16'h8001, 16'h8001, 1'b0);
        run("sh_ldi1", 4'd8, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0);
        run("sh_ldi3", 4'd8, 2'd3, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0);
        run("shl1", 4'd5, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0002, 1'b1);
        run("shr1", 4'd6, 2'd2, 2'd0, 2'd1, 16'h0, 16'h4000, 1'b1);
        run("shl0", 4'd5, 2'd2, 2'd0, 2'd3, 16'h0, 16'h8001, 1'b0);
        run("shr0", 4'd6, 2'd2, 2'd1, 2'd3, 16'h0, 16'h0001, 1'b0);
        run("and", 4'd2, 2'd2, 2'd0, 2'd1, 16'h0, 16'h0001, 1'b0);
        run("or", 4'd3, 2'd2, 2'd1, 2'd3, 16'h0, 16'h0001, 1'b0);
        run("xor", 4'd4, 2'd2, 2'd0, 2'd0, 16'h0, 16'h0000, 1'b0);
        chk("xor_zero", 32'(flag_zero_o), 32'd1);
        run("sub_borrow", 4'd1, 2'd2, 2'd1, 2'd0, 16'h0, 16'h8000, 1'b1);
        run("ldi15", 4'd8, 2'd3, 2'd0, 2'd0, 16'd15, 16'd15, 1'b0);
        run("shl15", 4'd5, 2'd2, 2'd0, 2'd3, 16'h0, 16'h8000, 1'b0);
        run("mov", 4'd9, 2'd3, 2'd0, 2'd0, 16'h0, 16'h8001, 1'b0);

        run("t6_ldi1", 4'd8, 2'd1, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        run("t6_ldi2", 4'd8, 2'd2, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0);
        run("t6_add", 4'd0, 2'd3, 2'd1, 2'd2, 16'h0, 16'h0000, 1'b1);
        d0 = done_cnt;
        a = last_en_cyc;
        issue(4'd12, 2'd0, 2'd1, 2'd2, 16'h1234);
        wait_idle();
        chk("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t6_no_write", 32'(last_en_cyc), 32'(a));
        chk("t6_r0_hold", 32'(tb_rf[0]), 32'h8001);
        chk("t6_zero_hold", 32'(flag_zero_o), 32'd1);
        chk("t6_carry_hold", 32'(flag_carry_o), 32'd1);

        old = mrf[2];
        issue(4'd7, 2'd2, 2'd1, 2'd2, 16'h0);
        mul_acc = acc_cyc;
        for (int i = 0; i < 20 && cyc < mul_acc + 6; i++) begin @(posedge clk); #1; end
        reset_ni = 1'b0;
        pend = 1'b0; mz = 1'b0; mc = 1'b0;
        mrf[2] = old;
        #1;
        chk("t5_ready", 32'(op_ready_o), 32'd1);
        chk("t5_zero", 32'(flag_zero_o), 32'd0);
        chk("t5_carry", 32'(flag_carry_o), 32'd0);
        chk("t5_en", 32'(rf_in_en_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("t5_r2_kept", 32'(tb_rf[2]), 32'h0001);
        chk("t5_no_write", 32'(last_en_cyc < mul_acc), 32'd1);

        run("t7_ldi", 4'd8, 2'd0, 2'd0, 2'd0, 16'h00A5, 16'h00A5, 1'b0);
        run("t7_mul", 4'd7, 2'd3, 2'd0, 2'd0, 16'h0, 16'h6A59, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("final_r%0d", i), 32'(tb_rf[i]), 32'(mrf[i]));

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
